axis_delay_calibrator: RTL and testbench
========================================

Name: axis_delay_calibrator

Overview:
- Sidecar monitor on the received ADC stream, directly upstream of the fine intra-cycle delay stage.
- After a software start pulse, finds the first sample that crosses a signed threshold. This sample is the pilot edge.
- Reports the measured latency split into a whole-cycle part and a sub-cycle sample part.
- intra_cycle_delay_count drives the fine delay stage; inter_cycle_delay_count drives the coarse cycle delay line.

Parameters:
- DATA_WIDTH, 256: stream width in bits.
- SAMPLE_PER_CYCLE, 16: samples per beat. Must be a power of 2.
- SAMPLE_WIDTH, 16: bits per sample, signed two's complement.
- MAX_CYCLES, 4096: search window in clock cycles before timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- cal_start  in  1  single-cycle pulse that starts a measurement.
- threshold  in  SAMPLE_WIDTH  signed detection threshold. Sampled on cal_start and held internally.
- s_axis_tdata  in  DATA_WIDTH  sample k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]. Sample 0 is earliest in time.
- s_axis_tvalid  in  1  beat valid. No backpressure.
- inter_cycle_delay_count  out  16  L / SAMPLE_PER_CYCLE.
- intra_cycle_delay_count  out  16  L mod SAMPLE_PER_CYCLE.
- total_delay_samples  out  32  measured latency L in samples.
- cal_busy  out  1  high while a measurement is in progress.
- cal_done  out  1  result valid. Held until the next cal_start.
- cal_timeout  out  1  no crossing found. Held until the next cal_start.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Cycle counter, trial counter and accumulator clear.
  - A reset mid-search aborts the search with no result.
- FSM states: IDLE, SEARCH, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT, cal_start=1:
  - Go to SEARCH; cnt<=0.
  - Latch threshold.
  - Clear cal_done and cal_timeout; set cal_busy.
  - Result outputs hold their old values until overwritten.
- SEARCH, each clock:
  - hit = s_axis_tvalid AND (some sample k has signed value > latched threshold). Comparison is strictly greater.
  - idx = lowest such k (priority encoder, sample 0 wins).
  - On hit: L = cnt*SAMPLE_PER_CYCLE + idx. Register the outputs, go to DONE, cal_done=1, cal_busy=0.
  - The beat present in the same cycle that cal_start is sampled is NOT examined. cnt=0 is the first beat after cal_start.
  - No hit: cnt<=cnt+1. cnt increments every clock, whether or not tvalid is high; tvalid-low cycles still count as elapsed time.
  - No hit with cnt==MAX_CYCLES-1: go to TIMEOUT, cal_timeout=1, cal_busy=0, result outputs set to 0.
  - cal_start during SEARCH is ignored.
- Output arithmetic:
  - Division and mod are shift and mask (SAMPLE_PER_CYCLE is a power of 2).
  - cnt width is clog2(MAX_CYCLES).
  - Outputs change only on the transition into DONE or TIMEOUT.
- Latency: cal_done rises one clock after the beat containing the crossing is presented.
- s_axis data is not forwarded; the block only monitors the stream.

Optional Feature:
- Macro: DELAY_CALIB_AVG_EN.
- Defined, 4-trial averaging:
  - A measurement consists of 4 trials. Each trial needs its own cal_start pulse, since software re-sends the pilot each time.
  - After trials 1-3 register a hit: add L to a 34-bit accumulator and return to a WAIT state. cal_busy stays 1 and cal_done stays 0.
  - In WAIT, cal_start moves to SEARCH with the trial count incremented.
  - After trial 4: L_avg = (sum + 2) >> 2, rounding half up. Split L_avg into the outputs and assert cal_done.
  - A timeout in any trial goes to TIMEOUT and clears the accumulator and trial count.
- Undefined: single trial only, as described in Behaviour. No WAIT state and no accumulator.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random data, then release -> all outputs 0, cal_busy=0.
- Basic hit: threshold=1000; cal_start; beats 0-4 all zeros; beat 5 has sample 3=2000 and sample 9=3000 -> L=83, inter=5, intra=3, cal_done=1 one clock after beat 5.
- Threshold boundary and sign: threshold=-5; sample=-5 -> no hit. threshold=-5; a later sample=-4 -> hit. A sample of 0x8000 never hits for threshold >= -32768.
- tvalid gaps: tvalid=0 on beats 0-2; crossing data is present on beat 1 but invalid, then valid at beat 3 sample 0 -> L=48.
- Timeout: MAX_CYCLES=64 and no crossing -> cal_timeout=1 on the clock after cnt=63, outputs 0. A new cal_start clears cal_timeout.
- Abort and restart: drop rst_n mid-SEARCH -> IDLE with all outputs 0. With DELAY_CALIB_AVG_EN, trials L=16,17,17,18 -> L_avg=17, intra=1, inter=1.

Source files
------------

// File: rtl/axis_delay_calibrator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axis_delay_calibrator_if                                   |
// | Purpose : AXI-Stream sample bus (no backpressure) seen by the        |
// |           delay calibrator monitor.                                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface axis_delay_calibrator_if #(
  parameter int DATA_WIDTH = 256
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface
`default_nettype wire

// File: rtl/axis_delay_calibrator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : axis_delay_calibrator                                      |
// | Purpose : Finds the first sample above a signed threshold after a    |
// |           start pulse and reports the latency as cycles + samples.   |
// |           Optional macro DELAY_CALIB_AVG_EN: 4-trial averaging.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module axis_delay_calibrator #(
  parameter int DATA_WIDTH       = 256,
  parameter int SAMPLE_PER_CYCLE = 16,
  parameter int SAMPLE_WIDTH     = 16,
  parameter int MAX_CYCLES       = 4096
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    i_cal_start,
  input  wire logic [SAMPLE_WIDTH-1:0] i_threshold,
  axis_delay_calibrator_if.slave       s_axis,
  output logic [15:0]                  o_inter_cycle_delay_count,
  output logic [15:0]                  o_intra_cycle_delay_count,
  output logic [31:0]                  o_total_delay_samples,
  output logic                         o_cal_busy,
  output logic                         o_cal_done,
  output logic                         o_cal_timeout
);

  localparam int                 c_CNT_W   = $clog2(MAX_CYCLES);
  localparam int                 c_IDX_W   = $clog2(SAMPLE_PER_CYCLE);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(MAX_CYCLES - 1);
  localparam logic [31:0]        c_MASK    = 32'(SAMPLE_PER_CYCLE - 1);

`ifdef DELAY_CALIB_AVG_EN
  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_DONE, S_TIMEOUT, S_WAIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE, S_TIMEOUT} state_t;
`endif

  state_t                         r_state;
  logic [c_CNT_W-1:0]             r_cnt;
  logic signed [SAMPLE_WIDTH-1:0] r_thr;
  logic [15:0]                    r_inter;
  logic [15:0]                    r_intra;
  logic [31:0]                    r_total;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_timeout;

  logic                           w_any;
  logic                           w_hit;
  logic [c_IDX_W-1:0]             w_idx;
  logic [31:0]                    w_lat;
  logic [31:0]                    w_res;

  // Scan from the latest sample down so the earliest crossing wins.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int k = SAMPLE_PER_CYCLE - 1; k >= 0; k--) begin
      if ($signed(s_axis.tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > r_thr) begin
        w_any = 1'b1;
        w_idx = c_IDX_W'(k);
      end
    end
  end

  assign w_hit = w_any & s_axis.tvalid;
  assign w_lat = (32'(r_cnt) << c_IDX_W) | 32'(w_idx);

`ifdef DELAY_CALIB_AVG_EN
  logic [33:0] r_acc;
  logic [1:0]  r_trial;
  logic [33:0] w_sum;
  logic [33:0] w_rnd;

  assign w_sum = r_acc + 34'(w_lat);
  assign w_rnd = w_sum + 34'd2;
  assign w_res = w_rnd[33:2];
`else
  assign w_res = w_lat;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_thr     <= '0;
      r_inter   <= '0;
      r_intra   <= '0;
      r_total   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
`ifdef DELAY_CALIB_AVG_EN
      r_acc     <= '0;
      r_trial   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (i_cal_start) begin
            r_state   <= S_SEARCH;
            r_cnt     <= '0;
            r_thr     <= i_threshold;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
`ifdef DELAY_CALIB_AVG_EN
            r_acc     <= '0;
            r_trial   <= '0;
`endif
          end
        end
`ifdef DELAY_CALIB_AVG_EN
        S_WAIT: begin
          if (i_cal_start) begin
            r_state <= S_SEARCH;
            r_cnt   <= '0;
            r_thr   <= i_threshold;
            r_trial <= r_trial + 2'd1;
          end
        end
`endif
        S_SEARCH: begin
          if (w_hit) begin
`ifdef DELAY_CALIB_AVG_EN
            if (r_trial != 2'd3) begin
              r_acc   <= w_sum;
              r_state <= S_WAIT;
            end else begin
              r_acc   <= '0;
              r_trial <= '0;
`endif
              r_total <= w_res;
              r_inter <= 16'(w_res >> c_IDX_W);
              r_intra <= 16'(w_res & c_MASK);
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
`ifdef DELAY_CALIB_AVG_EN
            end
`endif
          end else if (r_cnt == c_CNT_MAX) begin
            r_state   <= S_TIMEOUT;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_total   <= '0;
            r_inter   <= '0;
            r_intra   <= '0;
`ifdef DELAY_CALIB_AVG_EN
            r_acc     <= '0;
            r_trial   <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_inter_cycle_delay_count = r_inter;
  assign o_intra_cycle_delay_count = r_intra;
  assign o_total_delay_samples     = r_total;
  assign o_cal_busy                = r_busy;
  assign o_cal_done                = r_done;
  assign o_cal_timeout             = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_axis_delay_calibrator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_axis_delay_calibrator                                   |
// | Purpose : Directed self-checking bench for axis_delay_calibrator.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_axis_delay_calibrator;

  localparam int DW  = 256;
  localparam int SW  = 16;
  localparam int SPC = 16;
  localparam int MC  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cal_start;
  logic [SW-1:0] threshold;
  logic [15:0]   inter_cnt;
  logic [15:0]   intra_cnt;
  logic [31:0]   total;
  logic          busy;
  logic          done;
  logic          tmo;

  int n_cmp = 0;
  int n_err = 0;

  axis_delay_calibrator_if #(.DATA_WIDTH(DW)) axis_if ();

  axis_delay_calibrator #(
    .DATA_WIDTH      (DW),
    .SAMPLE_PER_CYCLE(SPC),
    .SAMPLE_WIDTH    (SW),
    .MAX_CYCLES      (MC)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .i_cal_start              (cal_start),
    .i_threshold              (threshold),
    .s_axis                   (axis_if.slave),
    .o_inter_cycle_delay_count(inter_cnt),
    .o_intra_cycle_delay_count(intra_cnt),
    .o_total_delay_samples    (total),
    .o_cal_busy               (busy),
    .o_cal_done               (done),
    .o_cal_timeout            (tmo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_busy, input logic e_done,
                         input logic e_tmo, input logic [31:0] e_total,
                         input logic [15:0] e_inter, input logic [15:0] e_intra);
    chk({tag, ".busy"},    32'(busy),      32'(e_busy));
    chk({tag, ".done"},    32'(done),      32'(e_done));
    chk({tag, ".timeout"}, 32'(tmo),       32'(e_tmo));
    chk({tag, ".total"},   total,          e_total);
    chk({tag, ".inter"},   32'(inter_cnt), 32'(e_inter));
    chk({tag, ".intra"},   32'(intra_cnt), 32'(e_intra));
  endtask

  function automatic logic [DW-1:0] beat_data(input int k, input logic [SW-1:0] v,
                                              input logic [SW-1:0] bg);
    logic [DW-1:0] d;
    for (int i = 0; i < SPC; i++) d[i*SW +: SW] = bg;
    if (k >= 0) d[k*SW +: SW] = v;
    return d;
  endfunction

  task automatic beat(input logic [DW-1:0] d, input logic v);
    axis_if.tdata  = d;
    axis_if.tvalid = v;
    tick();
  endtask

  task automatic start(input logic [SW-1:0] thr, input logic [DW-1:0] d);
    cal_start = 1'b1;
    threshold = thr;
    beat(d, 1'b1);
    cal_start = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_n          = 1'b0;
    cal_start      = 1'b0;
    threshold      = '0;
    axis_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      beat(d, 1'b1);
    end
    rst_n = 1'b1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);

`ifdef DELAY_CALIB_AVG_EN
    // Trials land at L = 16, 17, 17, 18 -> (68 + 2) >> 2 = 17.
    start(16'sd1000, '0);
    beat('0, 1'b1);
    beat(beat_data(0, 16'sd2000, 16'h0), 1'b1);
    chk("avg.t1.busy", 32'(busy), 32'd1);
    chk("avg.t1.done", 32'(done), 32'd0);
    start(16'sd1000, '0);
    beat('0, 1'b1);
    beat(beat_data(1, 16'sd2000, 16'h0), 1'b1);
    chk("avg.t2.busy", 32'(busy), 32'd1);
    chk("avg.t2.done", 32'(done), 32'd0);
    start(16'sd1000, '0);
    beat('0, 1'b1);
    beat(beat_data(1, 16'sd2000, 16'h0), 1'b1);
    chk("avg.t3.busy", 32'(busy), 32'd1);
    chk("avg.t3.done", 32'(done), 32'd0);
    start(16'sd1000, '0);
    beat('0, 1'b1);
    beat(beat_data(2, 16'sd2000, 16'h0), 1'b1);
    chk_all("avg.final", 0, 1, 0, 17, 1, 1);
`else
    // Crossing on the start beat itself is ignored; first real hit is beat 5.
    start(16'sd1000, beat_data(0, 16'sd5000, 16'h0));
    for (int b = 0; b < 5; b++) beat('0, 1'b1);
    chk_all("basic.pre", 1, 0, 0, 0, 0, 0);
    d = beat_data(3, 16'sd2000, 16'h0);
    d[9*SW +: SW] = 16'sd3000;
    beat(d, 1'b1);
    chk_all("basic", 0, 1, 0, 83, 5, 3);

    // Equal-to-threshold never hits; one above does.
    start(-16'sd5, '0);
    chk_all("sign.start", 1, 0, 0, 83, 5, 3);
    beat(beat_data(-1, 16'h0, -16'sd5), 1'b1);
    chk("sign.eq.done", 32'(done), 32'd0);
    beat(beat_data(7, -16'sd4, -16'sd5), 1'b1);
    chk_all("sign.gt", 0, 1, 0, 23, 1, 7);

    // Most-negative sample never exceeds the most-negative threshold.
    start(16'h8000, '0);
    beat(beat_data(-1, 16'h0, 16'h8000), 1'b1);
    beat(beat_data(-1, 16'h0, 16'h8000), 1'b1);
    chk("minval.done", 32'(done), 32'd0);
    beat(beat_data(15, 16'h8001, 16'h8000), 1'b1);
    chk_all("minval", 0, 1, 0, 47, 2, 15);

    // Invalid beats still advance the cycle count.
    start(16'sd1000, '0);
    beat('0, 1'b0);
    beat(beat_data(0, 16'sd2000, 16'h0), 1'b0);
    beat('0, 1'b0);
    chk("gap.done", 32'(done), 32'd0);
    beat(beat_data(0, 16'sd2000, 16'h0), 1'b1);
    chk_all("gap", 0, 1, 0, 48, 3, 0);

    // Reset mid-search abandons the search and clears the results.
    start(16'sd1000, '0);
    beat('0, 1'b1);
    beat('0, 1'b1);
    rst_n = 1'b0;
    beat(beat_data(0, 16'sd2000, 16'h0), 1'b1);
    rst_n = 1'b1;
    chk_all("abort", 0, 0, 0, 0, 0, 0);
    beat(beat_data(0, 16'sd2000, 16'h0), 1'b1);
    chk("abort.idle.done", 32'(done), 32'd0);

    // Timeout after MC beats; a mid-search cal_start must not restart cnt.
    start(16'sd1000, '0);
    for (int b = 0; b < MC - 1; b++) begin
      cal_start = (b == 20);
      beat('0, 1'b1);
    end
    cal_start = 1'b0;
    chk("tmo.pre.busy", 32'(busy), 32'd1);
    chk("tmo.pre.timeout", 32'(tmo), 32'd0);
    beat('0, 1'b1);
    chk_all("tmo", 0, 0, 1, 0, 0, 0);
    beat('0, 1'b1);
    chk("tmo.hold", 32'(tmo), 32'd1);
    start(16'sd1000, '0);
    chk("tmo.clear.timeout", 32'(tmo), 32'd0);
    chk("tmo.clear.busy", 32'(busy), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
